viterbi_acs_engine: RTL and testbench

VITERBI_ACS_ENGINE -- requirements
Module: viterbi_acs_engine

---
 rtl/viterbi_pkg.sv | 26 ++
 rtl/viterbi_acs_unit.sv | 55 +++++
 rtl/viterbi_acs_engine.sv | 162 ++++++++++++++++
 tb/tb_viterbi_acs_engine.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared definitions for the Viterbi add-compare-select engine: FSM state
// encoding, index-width helper and saturation limits of the metric format.
package viterbi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACS    = 2'd1,
        ST_COMMIT = 2'd2
    } acs_state_e;

    // Width of an index into n items; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Largest value of a w-bit two's-complement metric.
    function automatic longint sat_hi(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    // Smallest value of a w-bit two's-complement metric.
    function automatic longint sat_lo(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/viterbi_acs_unit.sv
// Combinational I-way add-compare-select for one destination state:
// candidates sat(delta[i] + logA[i]), strict-greater select (lowest index
// wins ties), then the emission term is added with saturation.
module viterbi_acs_unit
    import viterbi_pkg::*;
#(
    parameter int I = 4,
    parameter int W = 20,
    localparam int IW = idx_w(I)
) (
    input  logic [I*W-1:0]      delta,
    input  logic [I*W-1:0]      log_a,
    input  logic signed [W-1:0] log_b,
    output logic signed [W-1:0] new_metric,
    output logic [IW-1:0]       best_idx
);

    localparam logic signed [W+1:0] SAT_HI = (W+2)'(sat_hi(W));
    localparam logic signed [W+1:0] SAT_LO = (W+2)'(sat_lo(W));

    // Sign-extend a metric to the two guard bits used for every addition.
    function automatic logic signed [W+1:0] ext(input logic signed [W-1:0] v);
        return {{2{v[W-1]}}, v};
    endfunction

    // Clamp a widened sum back into the metric range.
    function automatic logic signed [W-1:0] sat(input logic signed [W+1:0] x);
        if (x > SAT_HI) begin
            return SAT_HI[W-1:0];
        end else if (x < SAT_LO) begin
            return SAT_LO[W-1:0];
        end
        return x[W-1:0];
    endfunction

    logic signed [W-1:0] cand;
    logic signed [W-1:0] best;

    // Scan predecessors in ascending order and keep the first strict maximum.
    always_comb begin
        // NOTE: every variable gets a value before any branch so no latch is inferred.
        cand     = '0;
        best     = sat(ext(delta[W-1:0]) + ext(log_a[W-1:0]));
        best_idx = '0;
        for (int i = 1; i < I; i++) begin
            cand = sat(ext(delta[i*W +: W]) + ext(log_a[i*W +: W]));
            if (cand > best) begin
                best     = cand;
                best_idx = IW'(i);
            end
        end
        new_metric = sat(ext(best) + ext(log_b));
    end

endmodule

// File: rtl/viterbi_acs_engine.sv
// One trellis step of a Viterbi decoder: evaluates one destination state per
// cycle, streams survivor pointers, then commits the new metric bank
// (optionally max-normalised) and reports the best state.
module viterbi_acs_engine
    import viterbi_pkg::*;
#(
    parameter int I       = 4,
    parameter int W       = 20,
    parameter int M       = 8,
    parameter int NORM_EN = 1,
    localparam int IW = idx_w(I),
    localparam int MW = idx_w(M)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                init_valid,
    input  logic [I*W-1:0]      delta_init,
    input  logic                start_valid,
    output logic                start_ready,
    input  logic [MW-1:0]       obs,
    output logic [MW-1:0]       obs_q,
    output logic [IW-1:0]       col_idx,
    input  logic [I*W-1:0]      logA_col,
    input  logic signed [W-1:0] logB_emit,
    output logic                psi_valid,
    output logic [IW-1:0]       psi_state,
    output logic [IW-1:0]       psi_out,
    output logic                done,
    output logic [IW-1:0]       best_state,
    output logic signed [W-1:0] best_delta
);

    localparam logic signed [W+1:0] SAT_HI = (W+2)'(sat_hi(W));
    localparam logic signed [W+1:0] SAT_LO = (W+2)'(sat_lo(W));

    function automatic logic signed [W+1:0] ext(input logic signed [W-1:0] v);
        return {{2{v[W-1]}}, v};
    endfunction

    function automatic logic signed [W-1:0] sat(input logic signed [W+1:0] x);
        if (x > SAT_HI) begin
            return SAT_HI[W-1:0];
        end else if (x < SAT_LO) begin
            return SAT_LO[W-1:0];
        end
        return x[W-1:0];
    endfunction

    acs_state_e          state;
    logic signed [W-1:0] cur_bank [I];
    logic signed [W-1:0] nxt_bank [I];
    logic signed [W-1:0] run_max;
    logic [IW-1:0]       run_arg;
    logic [I*W-1:0]      cur_flat;
    logic signed [W-1:0] acs_new;
    logic [IW-1:0]       acs_arg;
    logic signed [W-1:0] max_upd;
    logic [IW-1:0]       arg_upd;
    logic                last_col;

    // Steps are only taken from IDLE, and a same-cycle init wins over start.
    assign start_ready = rst_n && (state == ST_IDLE) && !init_valid;
    assign last_col    = (col_idx == IW'(I - 1));

    // Flatten the current bank for the add-compare-select unit.
    always_comb begin
        cur_flat = '0;
        for (int i = 0; i < I; i++) begin
            cur_flat[i*W +: W] = cur_bank[i];
        end
    end

    viterbi_acs_unit #(
        .I (I),
        .W (W)
    ) u_acs (
        .delta      (cur_flat),
        .log_a      (logA_col),
        .log_b      (logB_emit),
        .new_metric (acs_new),
        .best_idx   (acs_arg)
    );

    // Running max/argmax including the column being evaluated this cycle.
    always_comb begin
        max_upd = run_max;
        arg_upd = run_arg;
        if ((col_idx == '0) || (acs_new > run_max)) begin
            max_upd = acs_new;
            arg_upd = col_idx;
        end
    end

    // Control FSM, metric banks and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            obs_q      <= '0;
            col_idx    <= '0;
            psi_valid  <= 1'b0;
            psi_state  <= '0;
            psi_out    <= '0;
            done       <= 1'b0;
            best_state <= '0;
            best_delta <= '0;
            run_max    <= '0;
            run_arg    <= '0;
            // NOTE: the banks are reset too, so a step after reset starts from all-zero metrics.
            for (int i = 0; i < I; i++) begin
                cur_bank[i] <= '0;
                nxt_bank[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking throughout, so every branch sees pre-edge state.
            psi_valid <= 1'b0;
            done      <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (init_valid) begin
                        for (int i = 0; i < I; i++) begin
                            cur_bank[i] <= delta_init[i*W +: W];
                        end
                    end else if (start_valid) begin
                        obs_q   <= obs;
                        col_idx <= '0;
                        state   <= ST_ACS;
                    end
                end
                ST_ACS: begin
                    for (int i = 0; i < I; i++) begin
                        if (col_idx == IW'(i)) begin
                            nxt_bank[i] <= acs_new;
                        end
                    end
                    psi_valid <= 1'b1;
                    psi_state <= col_idx;
                    psi_out   <= acs_arg;
                    run_max   <= max_upd;
                    run_arg   <= arg_upd;
                    if (last_col) begin
                        col_idx    <= '0;
                        best_state <= arg_upd;
                        best_delta <= max_upd;
                        done       <= 1'b1;
                        state      <= ST_COMMIT;
                    end else begin
                        col_idx <= col_idx + 1'b1;
                    end
                end
                ST_COMMIT: begin
                    for (int i = 0; i < I; i++) begin
                        cur_bank[i] <= (NORM_EN != 0) ? sat(ext(nxt_bank[i]) - ext(run_max))
                                                      : nxt_bank[i];
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_viterbi_acs_engine.sv
// Self-checking bench: a normalising and a non-normalising engine share all
// inputs; a trellis-level model predicts survivors, best state and banks.
module tb_viterbi_acs_engine;

    localparam int I  = 3;
    localparam int W  = 20;
    localparam int M  = 8;
    localparam int IW = 2;
    localparam int MW = 3;
    localparam longint LIM_HI = (longint'(1) <<< (W - 1)) - 1;
    localparam longint LIM_LO = -(longint'(1) <<< (W - 1));

    logic                clk = 1'b0;
    logic                rst_n;
    logic                init_valid;
    logic [I*W-1:0]      delta_init;
    logic                start_valid;
    logic [MW-1:0]       obs;
    logic [I*W-1:0]      logA_col;
    logic signed [W-1:0] logB_emit;

    logic                start_ready_o [2];
    logic [MW-1:0]       obs_q_o       [2];
    logic [IW-1:0]       col_idx_o     [2];
    logic                psi_valid_o   [2];
    logic [IW-1:0]       psi_state_o   [2];
    logic [IW-1:0]       psi_out_o     [2];
    logic                done_o        [2];
    logic [IW-1:0]       best_state_o  [2];
    logic signed [W-1:0] best_delta_o  [2];

    int total = 0;
    int bad   = 0;

    logic signed [W-1:0] la [I][I];
    logic signed [W-1:0] lb [I][M];
    longint mb       [2][I];
    longint exp_bank [2][I];
    int     exp_psi  [2][I];
    int     exp_bs   [2];
    longint exp_bd   [2];
    int     seen_psi [2][I];
    longint init_v   [I];
    int     cur_obs;

    always #5 clk = ~clk;

    viterbi_acs_engine #(.I(I), .W(W), .M(M), .NORM_EN(1)) dut_n (
        .clk(clk), .rst_n(rst_n), .init_valid(init_valid), .delta_init(delta_init),
        .start_valid(start_valid), .start_ready(start_ready_o[0]), .obs(obs),
        .obs_q(obs_q_o[0]), .col_idx(col_idx_o[0]), .logA_col(logA_col),
        .logB_emit(logB_emit), .psi_valid(psi_valid_o[0]), .psi_state(psi_state_o[0]),
        .psi_out(psi_out_o[0]), .done(done_o[0]), .best_state(best_state_o[0]),
        .best_delta(best_delta_o[0])
    );

    viterbi_acs_engine #(.I(I), .W(W), .M(M), .NORM_EN(0)) dut_s (
        .clk(clk), .rst_n(rst_n), .init_valid(init_valid), .delta_init(delta_init),
        .start_valid(start_valid), .start_ready(start_ready_o[1]), .obs(obs),
        .obs_q(obs_q_o[1]), .col_idx(col_idx_o[1]), .logA_col(logA_col),
        .logB_emit(logB_emit), .psi_valid(psi_valid_o[1]), .psi_state(psi_state_o[1]),
        .psi_out(psi_out_o[1]), .done(done_o[1]), .best_state(best_state_o[1]),
        .best_delta(best_delta_o[1])
    );

    // External logA / logB tables, looked up by the engine's column and observation.
    always_comb begin
        logA_col  = '0;
        logB_emit = '0;
        if (int'(col_idx_o[0]) < I) begin
            for (int i = 0; i < I; i++) begin
                logA_col[i*W +: W] = la[i][col_idx_o[0]];
            end
            logB_emit = lb[col_idx_o[0]][obs_q_o[0]];
        end
    end

    function automatic longint clampw(input longint x);
        if (x > LIM_HI) return LIM_HI;
        if (x < LIM_LO) return LIM_LO;
        return x;
    endfunction

    function automatic logic signed [W-1:0] rand_metric();
        case ($urandom_range(0, 3))
            0:       return ($urandom_range(0, 1) != 0) ? W'(LIM_HI) : W'(LIM_LO);
            1:       return W'(longint'($urandom_range(0, 2000)) - 1000);
            default: return W'($urandom);
        endcase
    endfunction

    task automatic randomize_tables();
        for (int i = 0; i < I; i++) begin
            for (int j = 0; j < I; j++) la[i][j] = rand_metric();
            for (int m = 0; m < M; m++) lb[i][m] = rand_metric();
        end
    endtask

    // Trellis step at the level of the recursion: delta'[j] = max_i(delta[i]+A[i][j]) + B[j][o].
    task automatic model_step(input int o);
        longint nw [I];
        longint best, mx, c;
        int     arg;
        for (int k = 0; k < 2; k++) begin
            mx = 0;
            for (int j = 0; j < I; j++) begin
                best = 0;
                arg  = 0;
                for (int i = 0; i < I; i++) begin
                    c = clampw(mb[k][i] + longint'(la[i][j]));
                    if (i == 0 || c > best) begin
                        best = c;
                        arg  = i;
                    end
                end
                exp_psi[k][j] = arg;
                nw[j] = clampw(best + longint'(lb[j][o]));
                if (j == 0 || nw[j] > mx) begin
                    mx        = nw[j];
                    exp_bs[k] = j;
                end
            end
            exp_bd[k] = mx;
            for (int i = 0; i < I; i++) begin
                exp_bank[k][i] = (k == 0) ? clampw(nw[i] - mx) : nw[i];
                mb[k][i]       = exp_bank[k][i];
            end
        end
    endtask

    // Load init_v into both engines; starts and ends just after a falling edge.
    task automatic do_init();
        init_valid = 1'b1;
        for (int i = 0; i < I; i++) delta_init[i*W +: W] = W'(init_v[i]);
        @(negedge clk);
        init_valid = 1'b0;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < I; i++) mb[k][i] = init_v[i];
    endtask

    // Present one start request; returns at the falling edge after the accept.
    task automatic drive_start(input int o);
        cur_obs = o;
        model_step(o);
        obs         = MW'(o);
        start_valid = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (start_ready_o[k] !== 1'b1) begin
                bad++;
                $display("FAIL start_ready_idle inst%0d got=%0b want=1", k, start_ready_o[k]);
            end
        end
        @(negedge clk);
        start_valid = 1'b0;
    endtask

    // Follow one step to commit; with noise, start/init are held high during ACS.
    task automatic collect_step(input bit noise);
        int     np  [2];
        bit     gd  [2];
        int     lat [2];
        int     ps  [2][I];
        int     po  [2][I];
        int     gbs [2];
        longint gbd [2];
        for (int k = 0; k < 2; k++) begin
            np[k] = 0; gd[k] = 1'b0; lat[k] = 0; gbs[k] = 0; gbd[k] = 0;
        end
        for (int s = 0; s < I + 6; s++) begin
            if (noise) begin
                if (s < I) begin
                    start_valid = 1'b1;
                    init_valid  = 1'b1;
                    delta_init  = (I*W)'({$urandom, $urandom});
                end else begin
                    start_valid = 1'b0;
                    init_valid  = 1'b0;
                end
                if (s == 1) begin
                    #1;
                    for (int k = 0; k < 2; k++) begin
                        total++;
                        if (start_ready_o[k] !== 1'b0) begin
                            bad++;
                            $display("FAIL start_ready_busy inst%0d got=%0b want=0", k, start_ready_o[k]);
                        end
                    end
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (s == 0) begin
                    total++;
                    if (int'(obs_q_o[k]) !== cur_obs) begin
                        bad++;
                        $display("FAIL obs_q inst%0d got=%0d want=%0d", k, obs_q_o[k], cur_obs);
                    end
                end
                if (psi_valid_o[k] === 1'b1) begin
                    if (np[k] < I) begin
                        ps[k][np[k]] = int'(psi_state_o[k]);
                        po[k][np[k]] = int'(psi_out_o[k]);
                    end
                    np[k]++;
                end
                if (done_o[k] === 1'b1 && !gd[k]) begin
                    gd[k]  = 1'b1;
                    lat[k] = s;
                    gbs[k] = int'(best_state_o[k]);
                    gbd[k] = longint'(best_delta_o[k]);
                end
            end
            if (gd[0] && gd[1]) break;
            @(negedge clk);
        end
        start_valid = 1'b0;
        init_valid  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (!gd[k]) begin
                bad++;
                $display("FAIL done_timeout inst%0d got=none want=pulse", k);
            end else if (lat[k] != I) begin
                bad++;
                $display("FAIL done_latency inst%0d got=%0d want=%0d", k, lat[k] + 1, I + 1);
            end
            total++;
            if (np[k] != I) begin
                bad++;
                $display("FAIL psi_count inst%0d got=%0d want=%0d", k, np[k], I);
            end
            for (int j = 0; j < I && j < np[k]; j++) begin
                seen_psi[k][j] = po[k][j];
                total++;
                if (ps[k][j] != j || po[k][j] != exp_psi[k][j]) begin
                    bad++;
                    $display("FAIL psi inst%0d pulse%0d got=(%0d,%0d) want=(%0d,%0d)",
                             k, j, ps[k][j], po[k][j], j, exp_psi[k][j]);
                end
            end
            total++;
            if (gd[k] && (gbs[k] != exp_bs[k] || gbd[k] != exp_bd[k])) begin
                bad++;
                $display("FAIL best inst%0d got=(%0d,%0d) want=(%0d,%0d)",
                         k, gbs[k], gbd[k], exp_bs[k], exp_bd[k]);
            end
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (done_o[k] !== 1'b0 || start_ready_o[k] !== 1'b1) begin
                bad++;
                $display("FAIL after_commit inst%0d got=done%0b ready%0b want=done0 ready1",
                         k, done_o[k], start_ready_o[k]);
            end
        end
        for (int i = 0; i < I; i++) begin
            total++;
            if (longint'(dut_n.cur_bank[i]) != exp_bank[0][i]) begin
                bad++;
                $display("FAIL bank_norm[%0d] got=%0d want=%0d", i, dut_n.cur_bank[i], exp_bank[0][i]);
            end
            total++;
            if (longint'(dut_s.cur_bank[i]) != exp_bank[1][i]) begin
                bad++;
                $display("FAIL bank_raw[%0d] got=%0d want=%0d", i, dut_s.cur_bank[i], exp_bank[1][i]);
            end
        end
    endtask

    task automatic check_cleared(input string tag);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (start_ready_o[k] !== 1'b0 || psi_valid_o[k] !== 1'b0 || done_o[k] !== 1'b0 ||
                col_idx_o[k] !== '0 || obs_q_o[k] !== '0 || psi_state_o[k] !== '0 ||
                psi_out_o[k] !== '0 || best_state_o[k] !== '0 || best_delta_o[k] !== '0) begin
                bad++;
                $display("FAIL %s inst%0d got=rdy%0b pv%0b dn%0b col%0d obs%0d bs%0d bd%0d want=all0",
                         tag, k, start_ready_o[k], psi_valid_o[k], done_o[k], col_idx_o[k],
                         obs_q_o[k], best_state_o[k], best_delta_o[k]);
            end
        end
        for (int i = 0; i < I; i++) begin
            total++;
            if (dut_n.cur_bank[i] !== '0 || dut_s.cur_bank[i] !== '0) begin
                bad++;
                $display("FAIL %s_bank[%0d] got=(%0d,%0d) want=0", tag, i, dut_n.cur_bank[i], dut_s.cur_bank[i]);
            end
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (start_ready_o[k] !== 1'b1) begin
                bad++;
                $display("FAIL ready_after_reset inst%0d got=%0b want=1", k, start_ready_o[k]);
            end
            for (int i = 0; i < I; i++) mb[k][i] = 0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_cleared("reset");
        release_reset();
    endtask

    task automatic test_basic();
        init_v[0] = 0; init_v[1] = -5; init_v[2] = -10;
        for (int i = 0; i < I; i++) begin
            for (int j = 0; j < I; j++) la[i][j] = '0;
            for (int m = 0; m < M; m++) lb[i][m] = W'(-(i + 1));
        end
        do_init();
        drive_start(5);
        collect_step(1'b0);
        for (int j = 0; j < I; j++) begin
            total++;
            if (seen_psi[0][j] != 0) begin
                bad++;
                $display("FAIL basic_psi%0d got=%0d want=0", j, seen_psi[0][j]);
            end
            total++;
            if (longint'(dut_n.cur_bank[j]) != -longint'(j)) begin
                bad++;
                $display("FAIL basic_bank[%0d] got=%0d want=%0d", j, dut_n.cur_bank[j], -j);
            end
        end
        total++;
        if (best_state_o[0] !== 2'd0 || longint'(best_delta_o[0]) != -1) begin
            bad++;
            $display("FAIL basic_best got=(%0d,%0d) want=(0,-1)", best_state_o[0], best_delta_o[0]);
        end
    endtask

    task automatic test_tie();
        init_v[0] = -4; init_v[1] = -4; init_v[2] = -10;
        randomize_tables();
        for (int i = 0; i < I; i++)
            for (int j = 0; j < I; j++) la[i][j] = '0;
        do_init();
        drive_start(1);
        collect_step(1'b0);
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < I; j++) begin
                total++;
                if (seen_psi[k][j] != 0) begin
                    bad++;
                    $display("FAIL tie_psi inst%0d col%0d got=%0d want=0", k, j, seen_psi[k][j]);
                end
            end
        end
    endtask

    task automatic test_saturation();
        for (int pass = 0; pass < 2; pass++) begin
            longint lim;
            lim = (pass == 0) ? LIM_LO : LIM_HI;
            for (int i = 0; i < I; i++) begin
                init_v[i] = lim;
                for (int j = 0; j < I; j++) la[i][j] = (pass == 0) ? W'(-1) : W'(LIM_HI);
                for (int m = 0; m < M; m++) lb[i][m] = (pass == 0) ? W'(-1) : W'(LIM_HI);
            end
            do_init();
            drive_start(0);
            collect_step(1'b0);
            for (int i = 0; i < I; i++) begin
                total++;
                if (longint'(dut_s.cur_bank[i]) != lim) begin
                    bad++;
                    $display("FAIL sat_bank pass%0d [%0d] got=%0d want=%0d", pass, i, dut_s.cur_bank[i], lim);
                end
            end
            total++;
            if (longint'(best_delta_o[1]) != lim) begin
                bad++;
                $display("FAIL sat_best_delta pass%0d got=%0d want=%0d", pass, best_delta_o[1], lim);
            end
        end
    endtask

    task automatic test_handshake();
        randomize_tables();
        for (int i = 0; i < I; i++) init_v[i] = longint'(rand_metric());
        init_valid  = 1'b1;
        start_valid = 1'b1;
        obs         = MW'(6);
        for (int i = 0; i < I; i++) delta_init[i*W +: W] = W'(init_v[i]);
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (start_ready_o[k] !== 1'b0) begin
                bad++;
                $display("FAIL hs_ready_init inst%0d got=%0b want=0", k, start_ready_o[k]);
            end
            for (int i = 0; i < I; i++) mb[k][i] = init_v[i];
        end
        @(negedge clk);
        init_valid = 1'b0;
        drive_start(6);
        collect_step(1'b1);
    endtask

    task automatic test_reset_mid_step();
        randomize_tables();
        drive_start(3);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (col_idx_o[k] !== 2'd1) begin
                bad++;
                $display("FAIL midrst_col inst%0d got=%0d want=1", k, col_idx_o[k]);
            end
        end
        rst_n = 1'b0;
        #1;
        check_cleared("midrst");
        release_reset();
        randomize_tables();
        drive_start(4);
        collect_step(1'b0);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 20; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < I; i++) init_v[i] = longint'(rand_metric());
                do_init();
            end
            randomize_tables();
            drive_start(int'($urandom_range(0, M - 1)));
            collect_step(1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        init_valid  = 1'b0;
        start_valid = 1'b0;
        delta_init  = '0;
        obs         = '0;
        cur_obs     = 0;
        for (int i = 0; i < I; i++) begin
            for (int j = 0; j < I; j++) la[i][j] = '0;
            for (int m = 0; m < M; m++) lb[i][m] = '0;
        end
        test_reset();
        test_basic();
        test_tie();
        test_saturation();
        test_handshake();
        test_reset_mid_step();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
